// File: rtl/te_seq_pkg.sv
// te_seq_pkg: shared types and default constants for the radio timing
// engine sequencer.
//   te_seq_state_t  - sequencer FSM state encoding
//   *_DEF           - default parameter values for te_sequencer / te_seq_cnt
package te_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLL_WAIT = 3'd1,
    RAMP     = 3'd2,
    RX       = 3'd3,
    DISABLE  = 3'd4
  } te_seq_state_t;

  localparam int RAMP_CYCLES_DEF = 40;
  localparam int PLL_TIMEOUT_DEF = 1023;
  // Must hold max(RAMP_CYCLES, PLL_TIMEOUT) - 1.
  localparam int CNT_W_DEF       = 10;

endpackage

// File: rtl/te_seq_cnt.sv
// te_seq_cnt: loadable down-counter that saturates at zero. Shared by the
// ramp interval and the PLL-wait timeout.
// Ports:
//   ck, arst    - clock, async active-low reset (count clears to 0)
//   load        - load loadVal (wins over dec)
//   loadVal     - value to load
//   dec         - decrement by one; holds at 0, never wraps
//   zero        - count is 0
module te_seq_cnt
  import te_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ck,
  input  logic             arst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = loadVal;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/te_sequencer.sv
// te_sequencer: sequences the radio timing engine interface. Waits for PLL
// lock, raises radioEnable, times a ramp, raises radioRxEn, and tears down
// in order (RxEn first, then Enable) on stop, PLL loss or isolation.
// Optional build macro: TE_SEQ_TIMEOUT_EN (PLL-wait timeout with
// pllTimeout pulse; without it PLL_WAIT waits forever, pllTimeout stays 0).
// Ports:
//   ck, arst     - clock, async active-low reset
//   start, stop  - level requests to begin / end a sequence
//   pllSettled   - PLL lock (synchronous to ck)
//   tArstFs      - synchronous fast-clear, highest priority
//   isolateReq   - downstream isolation request; blocks start
//   isolateAck   - registered (isolateReq & state==IDLE)
//   radioEnable  - radio enable
//   radioRxEn    - receive enable
//   busy         - state != IDLE
//   pllLost      - 1-cycle pulse on PLL loss in RAMP/RX
//   pllTimeout   - 1-cycle pulse on PLL-wait timeout
// All outputs are registered.
module te_sequencer
  import te_seq_pkg::*;
#(
  parameter int RAMP_CYCLES = RAMP_CYCLES_DEF,
  parameter int PLL_TIMEOUT = PLL_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic ck,
  input  logic arst,
  input  logic start,
  input  logic stop,
  input  logic pllSettled,
  input  logic tArstFs,
  input  logic isolateReq,
  output logic isolateAck,
  output logic radioEnable,
  output logic radioRxEn,
  output logic busy,
  output logic pllLost,
  output logic pllTimeout
);

  localparam logic [CNT_W-1:0] RAMP_LD = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(PLL_TIMEOUT - 1);

  te_seq_state_t    state_q, state_d;
  logic             en_q, en_d;
  logic             rx_q, rx_d;
  logic             busy_q, busy_d;
  logic             lost_q, lost_d;
  logic             tmo_q, tmo_d;
  logic             ack_q, ack_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  te_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .ck      (ck),
    .arst    (arst),
    .load    (cnt_load),
    .loadVal (cnt_ld_val),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    rx_d       = rx_q;
    lost_d     = 1'b0;
    tmo_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = RAMP_LD;
    ack_d      = isolateReq && (state_q == IDLE);

    if (tArstFs) begin
      // Fast-clear skips the ordered teardown.
      state_d = IDLE;
      en_d    = 1'b0;
      rx_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop && !isolateReq) begin
            state_d = PLL_WAIT;
            // Timeout preload; unused when the timeout is compiled out.
            cnt_load   = 1'b1;
            cnt_ld_val = TMO_LD;
          end
        end
        PLL_WAIT: begin
          // stop beats a coincident pllSettled rise.
          if (stop || isolateReq)
            state_d = IDLE;
          else if (pllSettled) begin
            state_d    = RAMP;
            en_d       = 1'b1;
            cnt_load   = 1'b1;
            cnt_ld_val = RAMP_LD;
          end
`ifdef TE_SEQ_TIMEOUT_EN
          else if (cnt_zero) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end else
            cnt_dec = 1'b1;
`endif
        end
        RAMP: begin
          // Abort beats the counter expiring on the same cycle.
          if (stop || isolateReq || !pllSettled) begin
            state_d = DISABLE;
            rx_d    = 1'b0;
            lost_d  = !pllSettled;
          end else if (cnt_zero) begin
            state_d = RX;
            rx_d    = 1'b1;
          end else
            cnt_dec = 1'b1;
        end
        RX: begin
          if (stop || isolateReq || !pllSettled) begin
            state_d = DISABLE;
            rx_d    = 1'b0;
            lost_d  = !pllSettled;
          end
        end
        DISABLE: begin
          // RxEn already low; drop Enable one cycle later.
          state_d = IDLE;
          en_d    = 1'b0;
          rx_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
          en_d    = 1'b0;
          rx_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge ck or negedge arst) begin
    if (!arst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      rx_q    <= 1'b0;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      lost_q  <= lost_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
    end
  end

  assign isolateAck  = ack_q;
  assign radioEnable = en_q;
  assign radioRxEn   = rx_q;
  assign busy        = busy_q;
  assign pllLost     = lost_q;
  assign pllTimeout  = tmo_q;

endmodule

// File: tb/tb_te_sequencer.sv
// Bench for te_sequencer. Output vector order everywhere:
// {isolateAck, radioEnable, radioRxEn, busy, pllLost, pllTimeout}.
module tb_te_sequencer;

  logic ck = 1'b0;
  logic arst, start, stop, pllSettled, tArstFs, isolateReq;
  logic isolateAck, radioEnable, radioRxEn, busy, pllLost, pllTimeout;

  always #5 ck = ~ck;

  te_sequencer #(.RAMP_CYCLES(40), .PLL_TIMEOUT(16), .CNT_W(10)) dut (
    .ck          (ck),
    .arst        (arst),
    .start       (start),
    .stop        (stop),
    .pllSettled  (pllSettled),
    .tArstFs     (tArstFs),
    .isolateReq  (isolateReq),
    .isolateAck  (isolateAck),
    .radioEnable (radioEnable),
    .radioRxEn   (radioRxEn),
    .busy        (busy),
    .pllLost     (pllLost),
    .pllTimeout  (pllTimeout)
  );

  typedef struct {
    logic       st, sp, pll, tfs, iso;
    int         n;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic st, sp, pll, tfs, iso,
                              input int n, input logic [5:0] exp);
    vec_t v;
    v.st = st; v.sp = sp; v.pll = pll; v.tfs = tfs; v.iso = iso;
    v.n = n; v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic logic [5:0] outs();
    return {isolateAck, radioEnable, radioRxEn, busy, pllLost, pllTimeout};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    sb_t e;
    int  k;

    //    st sp pl tf is   n    ack en rx busy lost tmo
    // nominal sequence, stop in RX
    add(1, 0, 0, 0, 0,    1, 6'b000100);
    add(0, 0, 0, 0, 0,    4, 6'b000100);
    add(0, 0, 1, 0, 0,    1, 6'b010100);  // enable 1 cycle after lock
    add(0, 0, 1, 0, 0,   39, 6'b010100);  // still ramping
    add(0, 0, 1, 0, 0,    1, 6'b011100);  // RxEn exactly 40 after Enable
    add(0, 0, 1, 0, 0,    5, 6'b011100);
    add(0, 1, 1, 0, 0,    1, 6'b010100);  // RxEn off first
    add(0, 1, 1, 0, 0,    1, 6'b000000);  // then Enable, busy
    add(1, 1, 1, 0, 0,    2, 6'b000000);  // start+stop stays idle
    // PLL loss in RAMP
    add(1, 0, 1, 0, 0,    1, 6'b000100);
    add(0, 0, 1, 0, 0,    1, 6'b010100);
    add(0, 0, 1, 0, 0,   10, 6'b010100);
    add(0, 0, 0, 0, 0,    1, 6'b010110);  // pllLost pulse, DISABLE
    add(0, 0, 0, 0, 0,    1, 6'b000000);
    add(0, 0, 0, 0, 0,    3, 6'b000000);
    // stop coincident with lock in PLL_WAIT
    add(1, 0, 0, 0, 0,    1, 6'b000100);
    add(0, 1, 1, 0, 0,    1, 6'b000000);
    // stop coincident with counter at zero
    add(1, 0, 1, 0, 0,    1, 6'b000100);
    add(0, 0, 1, 0, 0,    1, 6'b010100);
    add(0, 0, 1, 0, 0,   39, 6'b010100);
    add(0, 1, 1, 0, 0,    1, 6'b010100);  // RxEn never rises
    add(0, 0, 1, 0, 0,    1, 6'b000000);
    // isolation in RX
    add(1, 0, 1, 0, 0,    1, 6'b000100);
    add(0, 0, 1, 0, 0,    1, 6'b010100);
    add(0, 0, 1, 0, 0,   40, 6'b011100);
    add(0, 0, 1, 0, 1,    1, 6'b010100);
    add(0, 0, 1, 0, 1,    1, 6'b000000);
    add(0, 0, 1, 0, 1,    1, 6'b100000);  // ack one cycle after IDLE
    add(1, 0, 1, 0, 1,    3, 6'b100000);  // start ignored while isolated
    add(0, 0, 1, 0, 0,    1, 6'b000000);
    // fast-clear in RX
    add(1, 0, 1, 0, 0,    1, 6'b000100);
    add(0, 0, 1, 0, 0,   41, 6'b011100);
    add(0, 0, 1, 1, 0,    1, 6'b000000);  // no ordered teardown
    add(0, 0, 1, 0, 0,    2, 6'b000000);
    add(1, 0, 1, 1, 1,    1, 6'b100000);  // ack survives fast-clear
    add(0, 0, 1, 0, 0,    1, 6'b000000);
    // PLL never locks
    add(1, 0, 0, 0, 0,    1, 6'b000100);
`ifdef TE_SEQ_TIMEOUT_EN
    add(0, 0, 0, 0, 0,   15, 6'b000100);
    add(0, 0, 0, 0, 0,    1, 6'b000001);  // timeout after 16 wait cycles
    add(0, 0, 0, 0, 0,    1, 6'b000000);
`else
    add(0, 0, 0, 0, 0, 2000, 6'b000100);  // waits indefinitely
    add(0, 1, 0, 0, 0,    1, 6'b000000);
`endif

    // reset with start held
    arst = 1'b0; start = 1'b1; stop = 1'b0; pllSettled = 1'b0;
    tArstFs = 1'b0; isolateReq = 1'b0;
    #1 check("reset", outs(), 6'b000000);
    repeat (3) @(posedge ck);
    @(negedge ck);
    check("reset_held", outs(), 6'b000000);
    arst = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; pllSettled = tbl[i].pll;
      tArstFs = tbl[i].tfs; isolateReq = tbl[i].iso;
      e.name = $sformatf("row%0d", i);
      e.exp  = tbl[i].exp;
      sbq.push_back(e);
      repeat (tbl[i].n) @(posedge ck);
      @(negedge ck);
      e = sbq.pop_front();
      check(e.name, outs(), e.exp);
    end

    // async reset mid-sequence: outputs drop without a clock edge
    start = 1'b1; stop = 1'b0; pllSettled = 1'b1; tArstFs = 1'b0; isolateReq = 1'b0;
    k = 0;
    while (!radioRxEn && k < 100) begin
      @(negedge ck);
      start = 1'b0;
      k++;
    end
    check("reach_rx", outs(), 6'b011100);
    #2 arst = 1'b0;
    #1 check("arst_async", outs(), 6'b000000);
    @(negedge ck);
    check("arst_hold", outs(), 6'b000000);
    arst = 1'b1;
    @(negedge ck);
    check("after_arst", outs(), 6'b000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/te_sequencer.md
# te_sequencer

Controller that sequences the radio timing engine interface: it waits for the PLL to settle, asserts `radioEnable`, times a ramp interval, then asserts `radioRxEn`, and tears the sequence down in order on stop, PLL loss or power-domain isolation. It sits in the always-on stage-1 domain, in front of the stage-2 consumers of the timing engine signals. It drives `radioEnable`/`radioRxEn` onto the interface in place of direct stage logic.

## Interface

Parameters:
- `RAMP_CYCLES`, 40, number of cycles from the rise of `radioEnable` to the rise of `radioRxEn`; legal range 1..1023.
- `PLL_TIMEOUT`, 1023, maximum number of `PLL_WAIT` cycles before abort (used only with `TE_SEQ_TIMEOUT_EN`); legal range 1..1023.
- `CNT_W`, 10, width of the shared down-counter; must be able to hold `max(RAMP_CYCLES, PLL_TIMEOUT) - 1`.

Ports (clock and reset first):
- `ck` input 1: single clock. All state updates on the rising edge.
- `arst` input 1: asynchronous reset, active-low.
- `start` input 1: level request to begin a sequence; sampled only in `IDLE`.
- `stop` input 1: level request to end a sequence.
- `pllSettled` input 1: PLL lock indication, already synchronous to `ck`.
- `tArstFs` input 1: synchronous fast-clear from the timing engine.
- `isolateReq` input 1: downstream domain is about to be isolated.
- `isolateAck` output 1: safe to isolate; `radioEnable` and `radioRxEn` are low.
- `radioEnable` output 1: radio enable to the interface.
- `radioRxEn` output 1: receive enable to the interface.
- `busy` output 1: high whenever the state is not `IDLE`.
- `pllLost` output 1: one-cycle pulse when `pllSettled` drops in `RAMP` or `RX`.
- `pllTimeout` output 1: one-cycle pulse when the PLL-wait timeout expires.

## Operation

- States: `IDLE`, `PLL_WAIT`, `RAMP`, `RX`, `DISABLE`. All outputs are registered.
- Reset (`arst` low): state is `IDLE`, counter is 0, all outputs are 0.
- `IDLE` → `PLL_WAIT` when `start=1`, `stop=0`, `isolateReq=0`.
- `PLL_WAIT` → `RAMP` when `pllSettled=1`.
  - `radioEnable` rises on the same edge.
  - The counter loads `RAMP_CYCLES-1`.
- `RAMP`: the counter decrements each cycle. When the counter is 0, the next state is `RX` and `radioRxEn` rises.
- `RX`: holds until an abort condition occurs.
- Abort conditions: `stop=1`, `isolateReq=1`, or `pllSettled=0` while in `RAMP` or `RX`.
  - From `PLL_WAIT`, an abort goes directly to `IDLE`.
  - From `RAMP` or `RX`, an abort goes to `DISABLE`.
  - A `pllSettled` loss additionally pulses `pllLost`.
- `DISABLE`: `radioRxEn` is 0 on entry. `radioEnable` clears on the next edge, and the state returns to `IDLE` on that same edge. The ordering is always RxEn off before Enable off.
- `isolateAck` = registered (`isolateReq` AND state is `IDLE`). While `isolateReq=1`, `start` is ignored.
- `tArstFs=1`: highest priority. On the next edge the state is `IDLE`, all outputs except `isolateAck` are 0, and no `DISABLE` ordering is applied.

## Timing

- `start` to `busy`: 1 cycle.
- `pllSettled` high in `PLL_WAIT` to `radioEnable`: 1 cycle.
- `radioEnable` rise to `radioRxEn` rise: exactly `RAMP_CYCLES` cycles.
- Abort in `RX` to `radioRxEn`=0: 1 cycle. Abort in `RX` to `radioEnable`=0: 2 cycles.
- Simultaneous events:
  - `start` and `stop` both high in `IDLE`: stay in `IDLE`.
  - `pllSettled` rise coincident with `stop` in `PLL_WAIT`: `stop` wins, next state is `IDLE`.
  - Counter reaching 0 coincident with `stop`: `stop` wins.
- `arst` asserted mid-sequence: outputs drop immediately and asynchronously to 0.
- Counter arithmetic: unsigned `CNT_W` bits, with no wrap. The counter saturates at 0 and only reloads on state entry.

## Configuration

- Macro: `TE_SEQ_TIMEOUT_EN`.
- With the macro defined:
  - On entry to `PLL_WAIT`, the counter loads `PLL_TIMEOUT-1` and decrements each cycle.
  - When the counter is 0 and `pllSettled=0`, the state goes to `IDLE` and `pllTimeout` pulses for 1 cycle.
- Without the macro: `PLL_WAIT` waits indefinitely and `pllTimeout` is tied to 0. The port list is unchanged.

## Structure

- Package `te_seq_pkg` contains:
  - the `te_seq_state_t` enum;
  - the default constants for `RAMP_CYCLES` and `PLL_TIMEOUT`;
  - the `CNT_W` default.
- Sub-module `te_seq_cnt` is a loadable saturating down-counter with `load`, `loadVal`, `dec` inputs and `zero` output. It is shared between the ramp and timeout functions.
- The FSM and output registers live in `te_sequencer`.

## Test plan

- Reset with `start=1` held → all outputs 0. After `arst` is released, `busy`=1 one cycle later.
- Nominal sequence, `RAMP_CYCLES`=40, `pllSettled` high 5 cycles after `start` → `radioEnable` rises at cycle 6; `radioRxEn` rises exactly 40 cycles later.
- `stop` in `RX` → `radioRxEn`=0 after 1 cycle, `radioEnable`=0 after 2 cycles, `busy`=0 after 2 cycles.
- `pllSettled` drops in `RAMP` → one-cycle `pllLost` pulse, `radioRxEn` never rises, state returns to `IDLE` via `DISABLE`.
- `isolateReq` in `RX` → ordered teardown; `isolateAck`=1 one cycle after `IDLE`. A `start` pulse while isolated is ignored.
- Timeout build, `PLL_TIMEOUT`=16, `pllSettled` held 0 → `pllTimeout` pulse after 16 `PLL_WAIT` cycles and return to `IDLE`. In the default build the sequencer stays in `PLL_WAIT` for 2000 cycles.
